// File: rtl/ahb_master_arbiter_if.sv
// ----------------------------------------------------------------------------
// ahb_master_arbiter_if
//
// Purpose: bundles every bus-side signal of the two-master AHB arbiter so the
// arbiter and its environment connect through one port.
//
// Signal summary
//   Master side (per master x = 0/1):
//     HADDR_Mx[31:0], HTRANS_Mx[1:0], HWRITE_Mx, HSIZE_Mx[2:0], HWDATA_Mx[31:0],
//     HMASTLOCK_Mx                     -> into the arbiter
//     HREADY_Mx, HRDATA_Mx[31:0]       <- from the arbiter
//   Slave side (shared):
//     HADDR[31:0], HTRANS[1:0], HWRITE, HSIZE[2:0], HWDATA[31:0] <- from arbiter
//     HREADY, HRDATA[31:0]                                       -> into arbiter
//   GRANT                              <- current address-phase owner
//
// Handshake: a master's transfer is accepted at the rising HCLK edge where its
// HTRANS is NONSEQ/SEQ and its HREADY_Mx is 1; while HREADY_Mx is 0 the master
// holds its address-phase signals unchanged.
//
// Modports
//   slave  : the arbiter's view
//   master : the environment's view (masters plus shared slave response)
// ----------------------------------------------------------------------------
interface ahb_master_arbiter_if;
    logic [31:0] HADDR_M0;
    logic [31:0] HADDR_M1;
    logic [1:0]  HTRANS_M0;
    logic [1:0]  HTRANS_M1;
    logic        HWRITE_M0;
    logic        HWRITE_M1;
    logic [2:0]  HSIZE_M0;
    logic [2:0]  HSIZE_M1;
    logic [31:0] HWDATA_M0;
    logic [31:0] HWDATA_M1;
    logic        HMASTLOCK_M0;
    logic        HMASTLOCK_M1;
    logic        HREADY_M0;
    logic        HREADY_M1;
    logic [31:0] HRDATA_M0;
    logic [31:0] HRDATA_M1;

    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;

    logic        GRANT;

    modport slave (
        input  HADDR_M0, HADDR_M1, HTRANS_M0, HTRANS_M1,
               HWRITE_M0, HWRITE_M1, HSIZE_M0, HSIZE_M1,
               HWDATA_M0, HWDATA_M1, HMASTLOCK_M0, HMASTLOCK_M1,
               HREADY, HRDATA,
        output HREADY_M0, HREADY_M1, HRDATA_M0, HRDATA_M1,
               HADDR, HTRANS, HWRITE, HSIZE, HWDATA, GRANT
    );

    modport master (
        output HADDR_M0, HADDR_M1, HTRANS_M0, HTRANS_M1,
               HWRITE_M0, HWRITE_M1, HSIZE_M0, HSIZE_M1,
               HWDATA_M0, HWDATA_M1, HMASTLOCK_M0, HMASTLOCK_M1,
               HREADY, HRDATA,
        input  HREADY_M0, HREADY_M1, HRDATA_M0, HRDATA_M1,
               HADDR, HTRANS, HWRITE, HSIZE, HWDATA, GRANT
    );
endinterface

// File: rtl/ahb_master_arbiter.sv
// ----------------------------------------------------------------------------
// ahb_master_arbiter
//
// Purpose: two-master AHB arbiter (M0 = CPU, M1 = DMAC) sharing one slave
// port. The address-phase owner (GRANT) changes only at an idle, unlocked,
// ready cycle of the owner while the other master presents NONSEQ; the
// data-phase owner (DOWN) trails GRANT by one accepted transfer and steers
// HWDATA.
//
// Ports
//   HCLK      : clock, rising edge
//   HRESETn   : synchronous active-low reset
//   bus       : ahb_master_arbiter_if.slave (all master/slave bus signals)
//   dbg_down  : data-phase owner register, exported for observation
// ----------------------------------------------------------------------------
module ahb_master_arbiter #(
    parameter bit DEFAULT_MASTER = 1'b0
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    ahb_master_arbiter_if.slave        bus,
    output logic                       dbg_down
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    logic grant_q, grant_d;
    logic down_q,  down_d;
    logic owner_idle, owner_lock, other_nonseq, sw;

    // State register
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            grant_q <= DEFAULT_MASTER;
            down_q  <= DEFAULT_MASTER;
        end else begin
            grant_q <= grant_d;
            down_q  <= down_d;
        end
    end

    // Next-state logic
    always_comb begin
        owner_idle   = 1'b0;
        owner_lock   = 1'b0;
        other_nonseq = 1'b0;
        if (grant_q) begin
            owner_idle   = (bus.HTRANS_M1 == TRANS_IDLE);
            owner_lock   = bus.HMASTLOCK_M1;
            other_nonseq = (bus.HTRANS_M0 == TRANS_NONSEQ);
        end else begin
            owner_idle   = (bus.HTRANS_M0 == TRANS_IDLE);
            owner_lock   = bus.HMASTLOCK_M0;
            other_nonseq = (bus.HTRANS_M1 == TRANS_NONSEQ);
        end
        // BUSY/SEQ are not idle, so an in-progress burst never loses the bus.
        sw      = bus.HREADY && owner_idle && !owner_lock && other_nonseq;
        grant_d = sw ? ~grant_q : grant_q;
        // The transfer accepted this edge belongs to the current address owner.
        down_d  = bus.HREADY ? grant_q : down_q;
    end

    // Output logic
    always_comb begin
        bus.GRANT     = grant_q;
        dbg_down      = down_q;

        bus.HADDR     = grant_q ? bus.HADDR_M1  : bus.HADDR_M0;
        bus.HTRANS    = grant_q ? bus.HTRANS_M1 : bus.HTRANS_M0;
        bus.HWRITE    = grant_q ? bus.HWRITE_M1 : bus.HWRITE_M0;
        bus.HSIZE     = grant_q ? bus.HSIZE_M1  : bus.HSIZE_M0;
        bus.HWDATA    = down_q  ? bus.HWDATA_M1 : bus.HWDATA_M0;

        bus.HRDATA_M0 = bus.HRDATA;
        bus.HRDATA_M1 = bus.HRDATA;

        // The non-owner sees ready only when it is not asking for the bus, which
        // holds any pending request in its address phase until handover.
        bus.HREADY_M0 = grant_q ? (bus.HTRANS_M0 == TRANS_IDLE) : bus.HREADY;
        bus.HREADY_M1 = grant_q ? bus.HREADY : (bus.HTRANS_M1 == TRANS_IDLE);
    end

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ahb_master_arbiter
//
// Bench for ahb_master_arbiter (DEFAULT_MASTER = 0). A behavioural model keeps
// who owns the address phase and the data phase, updated with the arbitration
// rules on every rising edge; a compare process checks every DUT output
// against it on each falling edge. Directed scenarios add literal checks.
// ----------------------------------------------------------------------------
module tb_ahb_master_arbiter;

    localparam int CLK_HALF = 5;

    logic HCLK;
    logic HRESETn;
    logic dbg_down;

    int n_checks = 0;
    int n_fail   = 0;

    ahb_master_arbiter_if bus ();

    ahb_master_arbiter #(.DEFAULT_MASTER(1'b0)) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .bus      (bus),
        .dbg_down (dbg_down)
    );

    // ---------------- clock ----------------
    initial begin
        HCLK = 1'b0;
        forever #CLK_HALF HCLK = ~HCLK;
    end

    // ---------------- reference model ----------------
    int m_grant = 0;
    int m_down  = 0;

    function automatic logic [1:0] trans_of(input int m);
        return (m == 0) ? bus.HTRANS_M0 : bus.HTRANS_M1;
    endfunction

    function automatic logic lock_of(input int m);
        return (m == 0) ? bus.HMASTLOCK_M0 : bus.HMASTLOCK_M1;
    endfunction

    always @(posedge HCLK) begin
        if (!HRESETn) begin
            m_grant = 0;
            m_down  = 0;
        end else if (bus.HREADY) begin
            int own;
            int oth;
            own    = m_grant;
            oth    = 1 - m_grant;
            m_down = own;
            if (trans_of(own) == 2'b00 && !lock_of(own) && trans_of(oth) == 2'b10)
                m_grant = oth;
        end
    end

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge HCLK) begin
        logic [31:0] e_addr, e_wdata;
        logic [1:0]  e_trans;
        logic        e_write;
        logic [2:0]  e_size;
        logic        e_rdy0, e_rdy1;
        e_addr  = (m_grant == 1) ? bus.HADDR_M1  : bus.HADDR_M0;
        e_trans = (m_grant == 1) ? bus.HTRANS_M1 : bus.HTRANS_M0;
        e_write = (m_grant == 1) ? bus.HWRITE_M1 : bus.HWRITE_M0;
        e_size  = (m_grant == 1) ? bus.HSIZE_M1  : bus.HSIZE_M0;
        e_wdata = (m_down  == 1) ? bus.HWDATA_M1 : bus.HWDATA_M0;
        e_rdy0  = (m_grant == 0) ? bus.HREADY : (bus.HTRANS_M0 == 2'b00);
        e_rdy1  = (m_grant == 1) ? bus.HREADY : (bus.HTRANS_M1 == 2'b00);
        chk("grant",     {31'd0, bus.GRANT},     m_grant);
        chk("down",      {31'd0, dbg_down},      m_down);
        chk("haddr",     bus.HADDR,              e_addr);
        chk("htrans",    {30'd0, bus.HTRANS},    {30'd0, e_trans});
        chk("hwrite",    {31'd0, bus.HWRITE},    {31'd0, e_write});
        chk("hsize",     {29'd0, bus.HSIZE},     {29'd0, e_size});
        chk("hwdata",    bus.HWDATA,             e_wdata);
        chk("hrdata_m0", bus.HRDATA_M0,          bus.HRDATA);
        chk("hrdata_m1", bus.HRDATA_M1,          bus.HRDATA);
        chk("hready_m0", {31'd0, bus.HREADY_M0}, {31'd0, e_rdy0});
        chk("hready_m1", {31'd0, bus.HREADY_M1}, {31'd0, e_rdy1});
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic at_neg();
        @(negedge HCLK);
    endtask

    task automatic bus_idle();
        bus.HADDR_M0 = 32'h0;  bus.HADDR_M1 = 32'h0;
        bus.HTRANS_M0 = 2'b00; bus.HTRANS_M1 = 2'b00;
        bus.HWRITE_M0 = 1'b0;  bus.HWRITE_M1 = 1'b0;
        bus.HSIZE_M0 = 3'd2;   bus.HSIZE_M1 = 3'd2;
        bus.HWDATA_M0 = 32'h0; bus.HWDATA_M1 = 32'h0;
        bus.HMASTLOCK_M0 = 1'b0; bus.HMASTLOCK_M1 = 1'b0;
        bus.HREADY = 1'b1;
        bus.HRDATA = 32'h0;
    endtask

    function automatic logic [1:0] rand_trans();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 3) return 2'b00;
        if (r <= 6) return 2'b10;
        if (r == 7) return 2'b01;
        return 2'b11;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0]  burst_t [4];
        logic [31:0] burst_d [4];
        burst_t = '{2'b11, 2'b01, 2'b11, 2'b11};
        burst_d = '{32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003, 32'hA5A5_0004};

        // Reset with both masters idle; slave stalling to show owner ready path.
        HRESETn = 1'b0;
        bus_idle();
        bus.HREADY = 1'b0;
        step();
        at_neg();
        chk("rst_grant", {31'd0, bus.GRANT}, 32'd0);
        chk("rst_rdy_m0_low", {31'd0, bus.HREADY_M0}, 32'd0);
        chk("rst_rdy_m1", {31'd0, bus.HREADY_M1}, 32'd1);
        bus.HREADY = 1'b1;
        step();
        at_neg();
        chk("rst_rdy_m0_high", {31'd0, bus.HREADY_M0}, 32'd1);
        HRESETn = 1'b1;

        // M1 NONSEQ write while M0 idle: one stall cycle, then handover.
        step();
        bus.HTRANS_M1 = 2'b10;
        bus.HADDR_M1  = 32'h2000_0000;
        bus.HWRITE_M1 = 1'b1;
        bus.HWDATA_M0 = 32'h1111_1111;
        bus.HWDATA_M1 = 32'hDEAD_BEEF;
        at_neg();
        chk("m1_req_grant", {31'd0, bus.GRANT}, 32'd0);
        chk("m1_req_stall", {31'd0, bus.HREADY_M1}, 32'd0);
        chk("m1_req_wdata_m0", bus.HWDATA, 32'h1111_1111);
        step();
        at_neg();
        chk("m1_addr_grant", {31'd0, bus.GRANT}, 32'd1);
        chk("m1_addr_haddr", bus.HADDR, 32'h2000_0000);
        chk("m1_addr_ready", {31'd0, bus.HREADY_M1}, 32'd1);
        chk("model_grant_1", m_grant, 32'd1);
        step();
        bus.HTRANS_M1 = 2'b00;
        at_neg();
        chk("m1_data_hwdata", bus.HWDATA, 32'hDEAD_BEEF);
        chk("m1_data_down", {31'd0, dbg_down}, 32'd1);

        // M0 read taken back, then wait states while M1 requests.
        step();
        bus.HTRANS_M0 = 2'b10;
        bus.HADDR_M0  = 32'h1000_0004;
        bus.HWRITE_M0 = 1'b0;
        at_neg();
        chk("m0_req_stall", {31'd0, bus.HREADY_M0}, 32'd0);
        step();
        bus.HTRANS_M1 = 2'b10;
        bus.HADDR_M1  = 32'h2000_0010;
        at_neg();
        chk("m0_addr_grant", {31'd0, bus.GRANT}, 32'd0);
        chk("m0_addr_haddr", bus.HADDR, 32'h1000_0004);
        step();
        bus.HTRANS_M0 = 2'b00;
        bus.HREADY    = 1'b0;
        bus.HRDATA    = 32'hCAFE_0001;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("wait_grant", {31'd0, bus.GRANT}, 32'd0);
            chk("wait_m1_stall", {31'd0, bus.HREADY_M1}, 32'd0);
            chk("wait_m0_rdy", {31'd0, bus.HREADY_M0}, 32'd0);
            chk("wait_hrdata_m1", bus.HRDATA_M1, 32'hCAFE_0001);
            step();
        end
        bus.HREADY = 1'b1;
        at_neg();
        chk("wait_end_grant", {31'd0, bus.GRANT}, 32'd0);
        step();
        at_neg();
        chk("after_wait_grant", {31'd0, bus.GRANT}, 32'd1);

        // M1 locked while idle keeps the bus; releasing the lock hands over.
        step();
        bus.HTRANS_M1    = 2'b00;
        bus.HMASTLOCK_M1 = 1'b1;
        bus.HTRANS_M0    = 2'b10;
        bus.HADDR_M0     = 32'h1000_0100;
        bus.HWRITE_M0    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("lock_grant", {31'd0, bus.GRANT}, 32'd1);
            chk("lock_m0_stall", {31'd0, bus.HREADY_M0}, 32'd0);
            step();
        end
        bus.HMASTLOCK_M1 = 1'b0;
        at_neg();
        chk("unlock_grant_same", {31'd0, bus.GRANT}, 32'd1);
        step();
        at_neg();
        chk("unlock_grant", {31'd0, bus.GRANT}, 32'd0);
        chk("model_grant_0", m_grant, 32'd0);

        // M0 burst with a BUSY beat; M1 waits until M0 goes idle.
        bus.HTRANS_M1 = 2'b10;
        bus.HADDR_M1  = 32'h2000_0020;
        bus.HWDATA_M1 = 32'h5A5A_5A5A;
        for (int i = 0; i < 4; i++) begin
            step();
            bus.HTRANS_M0 = burst_t[i];
            bus.HADDR_M0  = 32'h1000_0100 + 32'(4 * (i + 1));
            bus.HWDATA_M0 = burst_d[i];
            at_neg();
            chk("burst_grant", {31'd0, bus.GRANT}, 32'd0);
            chk("burst_m1_stall", {31'd0, bus.HREADY_M1}, 32'd0);
        end
        step();
        bus.HTRANS_M0 = 2'b00;
        at_neg();
        chk("burst_idle_grant", {31'd0, bus.GRANT}, 32'd0);
        step();
        at_neg();
        chk("burst_handover_grant", {31'd0, bus.GRANT}, 32'd1);
        chk("burst_last_wdata", bus.HWDATA, 32'hA5A5_0004);
        chk("burst_last_down", {31'd0, dbg_down}, 32'd0);
        chk("burst_handover_haddr", bus.HADDR, 32'h2000_0020);

        // One-cycle reset while M1 owns both phases.
        step();
        bus.HTRANS_M1 = 2'b00;
        at_neg();
        chk("pre_rst_down", {31'd0, dbg_down}, 32'd1);
        HRESETn = 1'b0;
        step();
        HRESETn = 1'b1;
        at_neg();
        chk("mid_rst_grant", {31'd0, bus.GRANT}, 32'd0);
        chk("mid_rst_down", {31'd0, dbg_down}, 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            step();
            HRESETn          = ($urandom_range(0, 249) != 0);
            bus.HTRANS_M0    = rand_trans();
            bus.HTRANS_M1    = rand_trans();
            bus.HMASTLOCK_M0 = ($urandom_range(0, 7) == 0);
            bus.HMASTLOCK_M1 = ($urandom_range(0, 7) == 0);
            bus.HREADY       = ($urandom_range(0, 3) != 0);
            bus.HADDR_M0     = $urandom;
            bus.HADDR_M1     = $urandom;
            bus.HWDATA_M0    = $urandom;
            bus.HWDATA_M1    = $urandom;
            bus.HRDATA       = $urandom;
            bus.HWRITE_M0    = 1'($urandom_range(0, 1));
            bus.HWRITE_M1    = 1'($urandom_range(0, 1));
            bus.HSIZE_M0     = 3'($urandom_range(0, 7));
            bus.HSIZE_M1     = 3'($urandom_range(0, 7));
        end
        step();
        at_neg();
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_master_arbiter.md
AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

Interface
REQ-001 Parameter DEFAULT_MASTER, default 0, SHALL select the master granted (parked) after reset: 0 = CPU (M0), 1 = DMAC (M1).
REQ-002 HCLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 HRESETn  input  1  SHALL be the synchronous, active-low reset, sampled on the HCLK rising edge.
REQ-004 HADDR_M0, HADDR_M1  input  32  SHALL be the master address buses.
REQ-005 HTRANS_M0, HTRANS_M1  input  2  SHALL be the master transfer types (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-006 HWRITE_M0, HWRITE_M1  input  1, and HSIZE_M0, HSIZE_M1  input  3, SHALL carry the master write flag and transfer size.
REQ-007 HWDATA_M0, HWDATA_M1  input  32  SHALL be the master write data.
REQ-008 HMASTLOCK_M0, HMASTLOCK_M1  input  1  SHALL be the per-master bus-lock requests.
REQ-009 HREADY_M0, HREADY_M1  output  1  SHALL be the per-master ready signals.
REQ-010 HRDATA_M0, HRDATA_M1  output  32  SHALL be the per-master read data.
REQ-011 HADDR  output  32, HTRANS  output  2, HWRITE  output  1, HSIZE  output  3 SHALL form the shared slave-side address phase.
REQ-012 HWDATA  output  32  SHALL be the shared slave-side write data.
REQ-013 HREADY  input  1  and  HRDATA  input  32  SHALL be the shared slave-side response.
REQ-014 GRANT  output  1  SHALL be the current address-phase owner (0 = M0, 1 = M1).

Function
REQ-015 Address mux: HADDR, HTRANS, HWRITE and HSIZE SHALL combinationally equal the signals of the master selected by GRANT.
REQ-016 Data-phase owner register (DOWN): when HREADY = 1, DOWN <= GRANT; otherwise DOWN holds.
REQ-017 HWDATA SHALL combinationally equal HWDATA of the master selected by DOWN.
REQ-018 HRDATA_M0 and HRDATA_M1 SHALL both equal HRDATA (broadcast).
REQ-019 Owner ready: HREADY_Mx for the master selected by GRANT SHALL equal HREADY.
REQ-020 Non-owner ready: HREADY_Mx for the other master SHALL be 0 when its HTRANS != 00, and 1 otherwise. A non-granted request is therefore stalled in its address phase.
REQ-021 Switch condition (SW) SHALL be the conjunction of the following:
- HREADY = 1;
- owner HTRANS = 00 exactly;
- owner HMASTLOCK = 0;
- other master HTRANS = 10 (NONSEQ).
REQ-022 When SW = 1, GRANT SHALL toggle at the next HCLK edge. When SW = 0, GRANT SHALL hold; this includes the case where neither master requests (parking).
REQ-023 Handover latency: a stalled request SHALL be accepted on the bus no earlier than 2 cycles after the owner first presents IDLE with HREADY = 1. There is one cycle for the GRANT update and one address cycle.
REQ-024 No switch SHALL occur while HREADY = 0, including during an extended data phase; GRANT SHALL be stable throughout wait states.
REQ-025 BUSY (01) or SEQ (11) from the owner SHALL block switching, so bursts are never split.
REQ-026 Asserted HMASTLOCK on the owner SHALL block switching even while the owner is IDLE.
REQ-027 Fairness: because the owner loses the bus at any qualifying idle cycle, alternating IDLE points SHALL yield round-robin service.
REQ-028 Simultaneous NONSEQ from both masters with the owner idle is impossible by definition. A request from the non-owner while the owner issues NONSEQ SHALL wait.

Reset
REQ-029 On HRESETn = 0 at an HCLK edge, GRANT and DOWN SHALL load DEFAULT_MASTER.
REQ-030 While HRESETn = 0, outputs SHALL follow REQ-015..020 using the reset GRANT and DOWN; no other state exists.
REQ-031 Reset asserted mid-transfer SHALL return GRANT to DEFAULT_MASTER at the next edge, with no recovery of the aborted transfer.

Verification
REQ-032 Reset, DEFAULT_MASTER = 0, both masters IDLE -> GRANT = 0, HREADY_M0 = HREADY, HREADY_M1 = 1.
REQ-033 M0 idle, M1 NONSEQ write to 0x2000_0000 with data 0xDEADBEEF -> HREADY_M1 = 0 for one cycle, then GRANT = 1, HADDR = 0x2000_0000, and HWDATA = 0xDEADBEEF in the next cycle.
REQ-034 M0 NONSEQ read at 0x1000_0004 with slave HREADY = 0 for 3 cycles while M1 requests -> GRANT stays 0 through the wait states, M1 stalled. M0 then goes IDLE -> GRANT = 1 on the following edge.
REQ-035 M1 owner with HMASTLOCK_M1 = 1 and HTRANS_M1 = 00 while M0 requests -> GRANT stays 1. Deassert the lock -> GRANT = 0 one edge later.
REQ-036 M0 4-beat SEQ burst with an interleaved BUSY while M1 requests -> no switch until M0 presents 00. HWDATA source follows DOWN, so the last M0 beat carries M0 data in the cycle GRANT becomes 1.
REQ-037 HRESETn pulsed low for one cycle while GRANT = 1 -> GRANT = 0 and DOWN = 0 at that edge.
